// File: rtl/jt51_wrqueue_pkg.sv
// Shared types for the JT51 CPU write queue: drain FSM states and the queued entry layout.
package jt51_wrqueue_pkg;

  localparam int unsigned ENTRY_W = 16;

  // Register-block address constants shared with benches
  localparam logic [7:0] REG_KON = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_DATA,
    ST_SETTLE,
    ST_WAIT
  } wq_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wq_entry_t;

endpackage

// File: rtl/jt51_fifo_sync.sv
// Generic synchronous FIFO with registered full/empty/level flags and a fall-through head word.
module jt51_fifo_sync #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout_c,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 2**AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout_c  = mem[rd_ptr[AW-1:0]];

  // Pointers carry an extra wrap bit; flags track level so they stay registered
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      case ({do_push, do_pop})
        2'b10: begin
          level <= level + (AW+1)'(1);
          full  <= (level == (AW+1)'(DEPTH-1));
          empty <= 1'b0;
        end
        2'b01: begin
          level <= level - (AW+1)'(1);
          full  <= 1'b0;
          empty <= (level == (AW+1)'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/jt51_wrqueue.sv
// CPU write queue in front of jt51_mmr: buffers {addr,data} pairs and replays them
// as address/data write sequences, waiting out the register block's busy window.
module jt51_wrqueue
  import jt51_wrqueue_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter bit          SKIP_ADDR  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr,
  input  logic                  cpu_a0,
  input  logic [7:0]            cpu_din,
  output logic                  cpu_full,
  output logic [DEPTH_LOG2:0]   cpu_level,
  output logic                  ovf,
  input  logic                  clr_ovf,
  output logic                  mmr_write,
  output logic                  mmr_a0,
  output logic [7:0]            mmr_din,
  input  logic                  mmr_busy
);

  logic [7:0]   cpu_addr;
  logic         push;
  logic         fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;
  wq_entry_t    head;

  wq_state_t    state, state_d;
  logic         pop_c;
  logic [7:0]   cur_addr, cur_addr_d;
  logic [7:0]   cur_data, cur_data_d;
  logic [7:0]   last_addr, last_addr_d;
  logic         last_valid, last_valid_d;
  logic         write_d;
  logic         a0_d;
  logic [7:0]   din_d;

  assign push = cpu_wr & cpu_a0;
  assign head = wq_entry_t'(fifo_dout);

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_addr <= 8'h00;
      ovf      <= 1'b0;
    end else begin
      if (cpu_wr && !cpu_a0) cpu_addr <= cpu_din;
      if (push && cpu_full)  ovf <= 1'b1;
      else if (clr_ovf)      ovf <= 1'b0;
    end
  end

  jt51_fifo_sync #(
    .DW (ENTRY_W),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop_c),
    .din    ({cpu_addr, cpu_din}),
    .dout_c (fifo_dout),
    .full   (cpu_full),
    .empty  (fifo_empty),
    .level  (cpu_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_addr   <= 8'h00;
      cur_data   <= 8'h00;
      last_addr  <= 8'h00;
      last_valid <= 1'b0;
      mmr_write  <= 1'b0;
      mmr_a0     <= 1'b0;
      mmr_din    <= 8'h00;
    end else begin
      state      <= state_d;
      cur_addr   <= cur_addr_d;
      cur_data   <= cur_data_d;
      last_addr  <= last_addr_d;
      last_valid <= last_valid_d;
      mmr_write  <= write_d;
      mmr_a0     <= a0_d;
      mmr_din    <= din_d;
    end
  end

  // Outputs are computed for the state being entered, so strobes line up with the state register
  always_comb begin
    state_d      = state;
    pop_c        = 1'b0;
    cur_addr_d   = cur_addr;
    cur_data_d   = cur_data;
    last_addr_d  = last_addr;
    last_valid_d = last_valid;
    write_d      = 1'b0;
    a0_d         = mmr_a0;
    din_d        = mmr_din;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_c      = 1'b1;
          cur_addr_d = head.addr;
          cur_data_d = head.data;
          write_d    = 1'b1;
          if (SKIP_ADDR && last_valid && (head.addr == last_addr)) begin
            state_d = ST_DATA;
            a0_d    = 1'b1;
            din_d   = head.data;
          end else begin
            state_d      = ST_ADDR;
            a0_d         = 1'b0;
            din_d        = head.addr;
            last_addr_d  = head.addr;
            last_valid_d = 1'b1;
          end
        end
      end
      ST_ADDR:   state_d = ST_GAP;
      ST_GAP: begin
        state_d = ST_DATA;
        write_d = 1'b1;
        a0_d    = 1'b1;
        din_d   = cur_data;
      end
      ST_DATA:   state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT:   if (!mmr_busy) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

endmodule
